// File: rtl/nand_sdr_target_emu.sv
// nand_sdr_target_emu
// Single-target ONFI SDR (asynchronous interface) NAND responder. The NAND
// strobes are oversampled on the system clock. The block answers RESET (FFh),
// READ STATUS (70h), READ ID (90h), PAGE READ (00h/30h) and PAGE PROGRAM
// (80h/10h) against a small internal page buffer, and drives R/B#.
//
// Ports
//   iSystemClock     system clock; all logic runs in this single domain
//   iReset           synchronous, active-high reset
//   iCE_n            chip enable, active low
//   iCLE / iALE      command / address latch enables
//   iWE_n            write enable; bus cycles are decoded on its rising edge
//   iRE_n            read enable; output data advances on its falling edge
//   iWP_n            write protect, active low
//   iDQ[7:0]         bus input
//   oDQ[7:0]         bus output data (held between RE edges)
//   oDQ_OE           bus output enable
//   oRB_n            ready/busy, low while busy
module nand_sdr_target_emu #(
  parameter int          PAGE_BYTES = 64,
  parameter logic [39:0] ID_VALUE   = 40'h2C_A4_E5_54_A9,
  parameter int          T_RST      = 100,
  parameter int          T_R        = 200,
  parameter int          T_PROG     = 400
) (
  input  logic       iSystemClock,
  input  logic       iReset,
  input  logic       iCE_n,
  input  logic       iCLE,
  input  logic       iALE,
  input  logic       iWE_n,
  input  logic       iRE_n,
  input  logic       iWP_n,
  input  logic [7:0] iDQ,
  output logic [7:0] oDQ,
  output logic       oDQ_OE,
  output logic       oRB_n
);

  localparam int PTR_W = (PAGE_BYTES > 1) ? $clog2(PAGE_BYTES) : 1;
  localparam int T_MAX = (T_PROG > T_R) ? ((T_PROG > T_RST) ? T_PROG : T_RST)
                                        : ((T_R > T_RST) ? T_R : T_RST);
  localparam int CNT_W = $clog2(T_MAX + 1);

  // The counter is loaded with T-1; together with the one cycle spent
  // registering the load, R/B# stays low for exactly T cycles.
  localparam logic [CNT_W-1:0] LD_RST  = CNT_W'(T_RST - 1);
  localparam logic [CNT_W-1:0] LD_R    = CNT_W'(T_R - 1);
  localparam logic [CNT_W-1:0] LD_PROG = CNT_W'(T_PROG - 1);

  // Synchroniser layout: {WP_n, CE_n, CLE, ALE, WE_n, RE_n, DQ[7:0]}
  localparam int SW = 14;
  localparam logic [SW-1:0] SYNC_INIT = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00};

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ID_ADDR,   // 90h seen, waiting for the single address byte
    ST_RD_ADDR,   // 00h seen, collecting 5 address bytes
    ST_RD_CONF,   // 5 addresses done, waiting for 30h
    ST_PG_ADDR,   // 80h seen, collecting 5 address bytes
    ST_DIN,       // accepting program data, waiting for 10h
    ST_DOUT,      // page data out
    ST_STAT,      // status out
    ST_ID,        // ID bytes out
    ST_BUSY       // array operation in progress
  } state_t;

  // ------------------------------------------------------------------
  // Two-flop synchronisers, one per input bit
  // ------------------------------------------------------------------
  logic [SW-1:0] sync_raw;
  logic [SW-1:0] sync_s;

  assign sync_raw = {iWP_n, iCE_n, iCLE, iALE, iWE_n, iRE_n, iDQ};

  genvar gi;
  generate
    for (gi = 0; gi < SW; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;
      always_ff @(posedge iSystemClock) begin
        if (iReset) begin
          s1_reg <= SYNC_INIT[gi];
          s2_reg <= SYNC_INIT[gi];
        end else begin
          s1_reg <= sync_raw[gi];
          s2_reg <= s1_reg;
        end
      end
      assign sync_s[gi] = s2_reg;
    end
  endgenerate

  logic       wp_s, ce_s, cle_s, ale_s, we_s, re_s;
  logic [7:0] dq_s;

  assign wp_s  = sync_s[13];
  assign ce_s  = sync_s[12];
  assign cle_s = sync_s[11];
  assign ale_s = sync_s[10];
  assign we_s  = sync_s[9];
  assign re_s  = sync_s[8];
  assign dq_s  = sync_s[7:0];

  // ------------------------------------------------------------------
  // Strobe edge detection and bus-cycle decode
  // ------------------------------------------------------------------
  logic we_prev_reg;
  logic re_prev_reg;

  // Previous-value flops track the strobes regardless of CE so that
  // re-enabling the chip with a strobe already low does not fake an edge.
  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      we_prev_reg <= 1'b1;
      re_prev_reg <= 1'b1;
    end else begin
      we_prev_reg <= we_s;
      re_prev_reg <= re_s;
    end
  end

  logic we_rise, re_fall;
  logic cmd_cyc, addr_cyc, din_cyc;

  assign we_rise  = ~ce_s & we_s & ~we_prev_reg;
  assign re_fall  = ~ce_s & ~re_s & re_prev_reg;
  assign cmd_cyc  = we_rise &  cle_s & ~ale_s;
  assign addr_cyc = we_rise & ~cle_s &  ale_s;
  assign din_cyc  = we_rise & ~cle_s & ~ale_s;

  // ------------------------------------------------------------------
  // Control state
  // ------------------------------------------------------------------
  state_t           state_reg;
  state_t           after_busy_reg;
  logic [2:0]       addr_cnt_reg;
  logic [7:0]       col_lo_reg;
  logic [PTR_W-1:0] ptr_reg;
  logic [2:0]       id_idx_reg;
  logic             fail_reg;
  logic [CNT_W-1:0] busy_cnt_reg;
  logic             rb_reg;
  logic [7:0]       dq_reg;
  logic             oe_reg;

  logic             busy;
  logic [7:0]       status_byte;
  logic [7:0]       id_byte;
  logic [7:0]       rd_data_reg;
  logic             mem_we;

  assign busy        = ~rb_reg;
  assign status_byte = {wp_s, rb_reg, rb_reg, 4'b0000, fail_reg};

  always_comb begin
    id_byte = 8'h00;
    case (id_idx_reg)
      3'd0:    id_byte = ID_VALUE[39:32];
      3'd1:    id_byte = ID_VALUE[31:24];
      3'd2:    id_byte = ID_VALUE[23:16];
      3'd3:    id_byte = ID_VALUE[15:8];
      3'd4:    id_byte = ID_VALUE[7:0];
      default: id_byte = 8'h00;
    endcase
  end

  // ------------------------------------------------------------------
  // Page buffer: write on accepted data-in, registered read of the
  // current pointer every cycle. The pointer only moves on strobe edges
  // that are several clocks apart, so rd_data_reg is always settled by
  // the next RE fall.
  // ------------------------------------------------------------------
  logic [7:0] mem [PAGE_BYTES];

  assign mem_we = din_cyc & (state_reg == ST_DIN) & wp_s & ~iReset;

  always_ff @(posedge iSystemClock) begin
    if (mem_we) begin
      mem[ptr_reg] <= dq_s;
    end
    rd_data_reg <= mem[ptr_reg];
  end

  // ------------------------------------------------------------------
  // Command / address / data FSM with busy timer and registered outputs.
  // Later assignments in this block override the busy-expiry defaults,
  // which is how FFh wins over a count that is just finishing.
  // ------------------------------------------------------------------
  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      state_reg      <= ST_IDLE;
      after_busy_reg <= ST_IDLE;
      addr_cnt_reg   <= 3'd0;
      col_lo_reg     <= 8'h00;
      ptr_reg        <= '0;
      id_idx_reg     <= 3'd0;
      fail_reg       <= 1'b0;
      busy_cnt_reg   <= '0;
      rb_reg         <= 1'b1;
      dq_reg         <= 8'h00;
      oe_reg         <= 1'b0;
    end else begin
      // Busy countdown runs independently of CE.
      if (busy_cnt_reg != '0) begin
        busy_cnt_reg <= busy_cnt_reg - CNT_W'(1);
      end else if (!rb_reg) begin
        rb_reg <= 1'b1;
        // If 70h moved us to STAT during busy we stay there.
        if (state_reg == ST_BUSY) begin
          state_reg <= after_busy_reg;
        end
      end

      oe_reg <= ~ce_s & ~re_s &
                ((state_reg == ST_DOUT) || (state_reg == ST_STAT) || (state_reg == ST_ID));

      if (cmd_cyc) begin
        if (dq_s == 8'hFF) begin
          busy_cnt_reg   <= LD_RST;
          rb_reg         <= 1'b0;
          fail_reg       <= 1'b0;
          state_reg      <= ST_BUSY;
          after_busy_reg <= ST_IDLE;
          addr_cnt_reg   <= 3'd0;
          id_idx_reg     <= 3'd0;
        end else if (busy) begin
          if (dq_s == 8'h70) begin
            state_reg <= ST_STAT;
          end
        end else begin
          case (state_reg)
            ST_IDLE, ST_DOUT, ST_STAT, ST_ID: begin
              case (dq_s)
                8'h70: state_reg <= ST_STAT;
                8'h90: state_reg <= ST_ID_ADDR;
                8'h00: begin
                  state_reg    <= ST_RD_ADDR;
                  addr_cnt_reg <= 3'd0;
                end
                8'h80: begin
                  state_reg    <= ST_PG_ADDR;
                  addr_cnt_reg <= 3'd0;
                end
                default: state_reg <= ST_IDLE;
              endcase
            end
            ST_RD_CONF: begin
              if (dq_s == 8'h30) begin
                busy_cnt_reg   <= LD_R;
                rb_reg         <= 1'b0;
                state_reg      <= ST_BUSY;
                after_busy_reg <= ST_DOUT;
              end else begin
                state_reg <= ST_IDLE;
              end
            end
            ST_DIN: begin
              if (dq_s == 8'h10) begin
                if (wp_s) begin
                  fail_reg       <= 1'b0;
                  busy_cnt_reg   <= LD_PROG;
                  rb_reg         <= 1'b0;
                  state_reg      <= ST_BUSY;
                  after_busy_reg <= ST_IDLE;
                end else begin
                  fail_reg  <= 1'b1;
                  state_reg <= ST_IDLE;
                end
              end else begin
                state_reg <= ST_IDLE;
              end
            end
            // A command while still collecting addresses is a count mismatch.
            default: state_reg <= ST_IDLE;
          endcase
        end
      end else if (addr_cyc) begin
        case (state_reg)
          ST_ID_ADDR: begin
            if (dq_s == 8'h00) begin
              state_reg  <= ST_ID;
              id_idx_reg <= 3'd0;
            end else begin
              state_reg <= ST_IDLE;
            end
          end
          ST_RD_ADDR, ST_PG_ADDR: begin
            addr_cnt_reg <= addr_cnt_reg + 3'd1;
            if (addr_cnt_reg == 3'd0) begin
              col_lo_reg <= dq_s;
            end
            if (addr_cnt_reg == 3'd1) begin
              // Column modulo page size: keep only the low pointer bits.
              ptr_reg <= PTR_W'({dq_s, col_lo_reg});
            end
            // Row bytes (counts 2..4) carry no meaning for a single page.
            if (addr_cnt_reg == 3'd4) begin
              state_reg <= (state_reg == ST_RD_ADDR) ? ST_RD_CONF : ST_DIN;
            end
          end
          default: ;
        endcase
      end else if (din_cyc && state_reg == ST_DIN) begin
        ptr_reg <= ptr_reg + PTR_W'(1);
      end else if (re_fall) begin
        case (state_reg)
          ST_DOUT: begin
            dq_reg  <= rd_data_reg;
            ptr_reg <= ptr_reg + PTR_W'(1);
          end
          ST_STAT: dq_reg <= status_byte;
          ST_ID: begin
            dq_reg <= id_byte;
            // Saturate past the last ID byte so further reads return 00h.
            if (id_idx_reg != 3'd5) begin
              id_idx_reg <= id_idx_reg + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign oDQ    = dq_reg;
  assign oDQ_OE = oe_reg;
  assign oRB_n  = rb_reg;

endmodule

// File: tb/tb_nand_sdr_target_emu.sv
// Testbench for nand_sdr_target_emu: a table of bus transactions applied in
// a loop, plus hand-written sequences for busy interruption and reset.
// Expected read bytes go through a scoreboard queue.
module tb_nand_sdr_target_emu;

  localparam int PAGE_BYTES = 64;
  localparam int T_RST      = 100;
  localparam int T_R        = 200;
  localparam int T_PROG     = 400;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce_n, cle, ale, we_n, re_n, wp_n;
  logic [7:0] dq_in;
  logic [7:0] dq_out;
  logic       dq_oe;
  logic       rb_n;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  nand_sdr_target_emu #(
    .PAGE_BYTES(PAGE_BYTES),
    .ID_VALUE  (40'h2C_A4_E5_54_A9),
    .T_RST     (T_RST),
    .T_R       (T_R),
    .T_PROG    (T_PROG)
  ) dut (
    .iSystemClock(clk),
    .iReset      (rst),
    .iCE_n       (ce_n),
    .iCLE        (cle),
    .iALE        (ale),
    .iWE_n       (we_n),
    .iRE_n       (re_n),
    .iWP_n       (wp_n),
    .iDQ         (dq_in),
    .oDQ         (dq_out),
    .oDQ_OE      (dq_oe),
    .oRB_n       (rb_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // R/B# monitor: length of each low run and the cycle at which it ended.
  int low_run = 0;
  int last_low_len = 0;
  int rise_cyc = 0;
  int rises = 0;

  always @(negedge clk) begin
    if (!rb_n) begin
      low_run <= low_run + 1;
    end else begin
      if (low_run != 0) begin
        last_low_len <= low_run;
        rise_cyc     <= cyc;
        rises        <= rises + 1;
      end
      low_run <= 0;
    end
  end

  // Scoreboard of expected read bytes.
  logic [7:0] exp_q[$];

  typedef enum int {K_CMD, K_ADDR, K_DIN, K_RD, K_RDZ, K_WP, K_CE, K_RDY, K_NOBUSY} kind_e;
  typedef struct {
    kind_e      kind;
    logic [7:0] val;
    int         exp;
  } step_t;

  step_t steps[$];
  int    we_cyc = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic bus_write(input logic c, input logic a, input logic [7:0] d);
    cle = c; ale = a; dq_in = d;
    tick(4);
    we_n = 1'b0;
    tick(4);
    we_n = 1'b1;
    we_cyc = cyc;
    tick(4);
    cle = 1'b0; ale = 1'b0;
    tick(1);
    $display("  write cle=%0b ale=%0b dq=%02h", c, a, d);
  endtask

  task automatic do_read(input logic [7:0] exp, input string name);
    logic [7:0] e;
    exp_q.push_back(exp);
    re_n = 1'b0;
    tick(6);
    check({name, "_oe_low"}, 32'(dq_oe), 32'd1);
    e = exp_q.pop_front();
    check(name, 32'(dq_out), 32'(e));
    $display("  read  %s dq=%02h expected %02h", name, dq_out, e);
    re_n = 1'b1;
    tick(6);
    check({name, "_oe_high"}, 32'(dq_oe), 32'd0);
  endtask

  task automatic read_none(input string name);
    re_n = 1'b0;
    tick(6);
    check({name, "_no_drive"}, 32'(dq_oe), 32'd0);
    $display("  read  %s oe=%0b (no drive expected)", name, dq_oe);
    re_n = 1'b1;
    tick(6);
  endtask

  task automatic wait_ready(input int exp_len, input string name);
    check({name, "_busy_started"}, 32'(rb_n), 32'd0);
    for (int k = 0; k < 3000 && !rb_n; k++) tick(1);
    check({name, "_ready"}, 32'(rb_n), 32'd1);
    tick(1);
    check({name, "_busy_len"}, 32'(last_low_len), 32'(exp_len));
    $display("  busy  %s low for %0d cycles", name, last_low_len);
  endtask

  task automatic no_busy(input string name);
    int r0;
    r0 = rises;
    tick(30);
    check({name, "_rb_high"}, 32'(rb_n), 32'd1);
    check({name, "_no_pulse"}, 32'(rises), 32'(r0));
    $display("  idle  %s rb_n=%0b", name, rb_n);
  endtask

  task automatic cmd_addr5(input logic [7:0] cmd, input logic [7:0] col);
    bus_write(1'b1, 1'b0, cmd);
    bus_write(1'b0, 1'b1, col);
    for (int k = 0; k < 4; k++) bus_write(1'b0, 1'b1, 8'h00);
  endtask

  function automatic void add(input kind_e k, input logic [7:0] v, input int e);
    step_t s;
    s.kind = k; s.val = v; s.exp = e;
    steps.push_back(s);
  endfunction

  function automatic void add_a5(input logic [7:0] cmd, input logic [7:0] col);
    add(K_CMD, cmd, 0);
    add(K_ADDR, col, 0);
    for (int k = 0; k < 4; k++) add(K_ADDR, 8'h00, 0);
  endfunction

  function automatic void build_steps();
    // Status after reset, then READ ID with a CE-high gap.
    add(K_CMD, 8'h70, 0); add(K_RD, 8'h00, 'hE0);
    add(K_CMD, 8'h90, 0); add(K_ADDR, 8'h00, 0);
    add(K_RD, 0, 'h2C); add(K_CE, 1, 0); add(K_RDZ, 0, 0); add(K_CE, 0, 0);
    add(K_RD, 0, 'hA4); add(K_RD, 0, 'hE5); add(K_RD, 0, 'h54);
    add(K_RD, 0, 'hA9); add(K_RD, 0, 'h00);
    // READ ID with a non-zero address returns to IDLE.
    add(K_CMD, 8'h90, 0); add(K_ADDR, 8'h01, 0); add(K_RDZ, 0, 0);
    // Program 11 22 33 at column 4, read back.
    add(K_WP, 1, 0);
    add_a5(8'h80, 8'h04);
    add(K_DIN, 8'h11, 0); add(K_DIN, 8'h22, 0); add(K_DIN, 8'h33, 0);
    add(K_CMD, 8'h10, 0); add(K_RDY, 0, T_PROG);
    add(K_CMD, 8'h70, 0); add(K_RD, 0, 'hE0);
    add_a5(8'h00, 8'h04);
    add(K_CMD, 8'h30, 0); add(K_RDY, 0, T_R);
    add(K_RD, 0, 'h11); add(K_RD, 0, 'h22); add(K_RD, 0, 'h33);
    // Program while write protected: no busy, FAIL set, buffer untouched.
    add(K_WP, 0, 0);
    add_a5(8'h80, 8'h04);
    add(K_DIN, 8'h55, 0); add(K_DIN, 8'h66, 0);
    add(K_CMD, 8'h10, 0); add(K_NOBUSY, 0, 0);
    add(K_CMD, 8'h70, 0); add(K_RD, 0, 'h61);
    add(K_WP, 1, 0);
    add_a5(8'h00, 8'h04);
    add(K_CMD, 8'h30, 0); add(K_RDY, 0, T_R);
    add(K_RD, 0, 'h11); add(K_RD, 0, 'h22);
    // Column wrap on program and on read.
    add_a5(8'h80, 8'(PAGE_BYTES - 1));
    add(K_DIN, 8'hAA, 0); add(K_DIN, 8'hBB, 0);
    add(K_CMD, 8'h10, 0); add(K_RDY, 0, T_PROG);
    add(K_CMD, 8'h70, 0); add(K_RD, 0, 'hE0);
    add_a5(8'h00, 8'(PAGE_BYTES - 1));
    add(K_CMD, 8'h30, 0); add(K_RDY, 0, T_R);
    add(K_RD, 0, 'hAA); add(K_RD, 0, 'hBB);
    add_a5(8'h00, 8'h00);
    add(K_CMD, 8'h30, 0); add(K_RDY, 0, T_R);
    add(K_RD, 0, 'hBB);
    // Address count mismatch: command after 2 addresses returns to IDLE.
    add(K_CMD, 8'h00, 0); add(K_ADDR, 8'h04, 0); add(K_ADDR, 8'h00, 0);
    add(K_CMD, 8'h30, 0); add(K_NOBUSY, 0, 0); add(K_RDZ, 0, 0);
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ff_cyc;
    string nm;
    rst = 1'b1; ce_n = 1'b0; cle = 1'b0; ale = 1'b0;
    we_n = 1'b1; re_n = 1'b1; wp_n = 1'b1; dq_in = 8'h00;
    tick(5);
    rst = 1'b0;
    tick(5);
    check("reset_rb_n", 32'(rb_n), 32'd1);
    check("reset_oe", 32'(dq_oe), 32'd0);
    check("reset_dq", 32'(dq_out), 32'h00);

    build_steps();
    for (int i = 0; i < steps.size(); i++) begin
      nm = $sformatf("step%0d", i);
      case (steps[i].kind)
        K_CMD:    bus_write(1'b1, 1'b0, steps[i].val);
        K_ADDR:   bus_write(1'b0, 1'b1, steps[i].val);
        K_DIN:    bus_write(1'b0, 1'b0, steps[i].val);
        K_RD:     do_read(8'(steps[i].exp), nm);
        K_RDZ:    read_none(nm);
        K_WP:     begin wp_n = steps[i].val[0]; tick(6); end
        K_CE:     begin ce_n = steps[i].val[0]; tick(6); end
        K_RDY:    wait_ready(steps[i].exp, nm);
        K_NOBUSY: no_busy(nm);
        default:  ;
      endcase
    end

    // Status during T_R busy, then FFh restarts busy for T_RST.
    cmd_addr5(8'h00, 8'h04);
    bus_write(1'b1, 1'b0, 8'h30);
    check("tr_busy_low", 32'(rb_n), 32'd0);
    bus_write(1'b1, 1'b0, 8'h70);
    do_read(8'h80, "stat_busy");
    bus_write(1'b1, 1'b0, 8'hFF);
    ff_cyc = we_cyc;
    check("ff_still_busy", 32'(rb_n), 32'd0);
    for (int k = 0; k < 3000 && !rb_n; k++) tick(1);
    check("ff_ready", 32'(rb_n), 32'd1);
    tick(1);
    // WE_n rise -> 2 sync flops -> detect cycle -> load, then T_RST low cycles.
    check("ff_latency", 32'(rise_cyc - ff_cyc), 32'(T_RST + 3));
    $display("  busy  ff latency %0d cycles", rise_cyc - ff_cyc);
    bus_write(1'b1, 1'b0, 8'h70);
    do_read(8'hE0, "stat_after_ff");

    // Reset in the middle of DOUT with RE_n held low.
    cmd_addr5(8'h00, 8'h04);
    bus_write(1'b1, 1'b0, 8'h30);
    wait_ready(T_R, "dout_pre_rst");
    do_read(8'h11, "dout_first");
    re_n = 1'b0;
    tick(6);
    check("dout_mid_oe", 32'(dq_oe), 32'd1);
    check("dout_mid_dq", 32'(dq_out), 32'h22);
    rst = 1'b1;
    tick(1);
    check("rst_mid_rb_n", 32'(rb_n), 32'd1);
    check("rst_mid_oe", 32'(dq_oe), 32'd0);
    check("rst_mid_dq", 32'(dq_out), 32'h00);
    $display("  reset mid-dout rb_n=%0b oe=%0b dq=%02h", rb_n, dq_oe, dq_out);
    rst = 1'b0;
    re_n = 1'b1;
    tick(6);
    read_none("after_rst");
    check("after_rst_dq", 32'(dq_out), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
